// File: rtl/serial_adder_if.sv
// ============================================================================
// serial_adder_if : start/done handshake bundle for serial_adder.
// Optional macro: SERIAL_ADDER_SUB_EN adds the sub select signal.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             ovf;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output start, a, b, cin, sub, input  busy, done, s, c, ovf);
    modport slave  (input  start, a, b, cin, sub, output busy, done, s, c, ovf);
`else
    modport master (output start, a, b, cin, input  busy, done, s, c, ovf);
    modport slave  (input  start, a, b, cin, output busy, done, s, c, ovf);
`endif
endinterface

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// serial_adder : multi-cycle adder, DIGIT bits per clock LSB first, with carry
// and signed overflow. Optional macro: SERIAL_ADDER_SUB_EN (a - b via sub).
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    generate
        if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
            $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] s_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;
    logic             c_q;
    logic             ovf_q;

    logic [DIGIT:0]   digit_d;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] b_load_d;
    logic             cin_load_d;
    logic             msb_cin_d;

`ifdef SERIAL_ADDER_SUB_EN
    assign b_load_d   = bus.sub ? ~bus.b : bus.b;
    assign cin_load_d = bus.sub | bus.cin;
`else
    assign b_load_d   = bus.b;
    assign cin_load_d = bus.cin;
`endif

    always_comb begin
        digit_d = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
        // Carry into the digit's top bit; on the final digit that is the carry into the MSB.
        msb_cin_d = digit_d[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
        sum_d     = (sum_q >> DIGIT) | (WIDTH'(digit_d[DIGIT-1:0]) << (WIDTH - DIGIT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            c_q     <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= b_load_d;
                        carry_q <= cin_load_d;
                        sum_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    sum_q   <= sum_d;
                    carry_q <= digit_d[DIGIT];
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        s_q     <= sum_d;
                        c_q     <= digit_d[DIGIT];
                        ovf_q   <= digit_d[DIGIT] ^ msb_cin_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.s    = s_q;
    assign bus.c    = c_q;
    assign bus.ovf  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// tb_serial_adder : scoreboard bench for serial_adder in three configurations
// (8x1, 8x4, 16x2). Optional macro: SERIAL_ADDER_SUB_EN enables the sub test.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8))  if81 ();
    serial_adder_if #(.WIDTH(8))  if84 ();
    serial_adder_if #(.WIDTH(16)) if162 ();

    serial_adder #(.WIDTH(8),  .DIGIT(1)) u_add_8x1  (.clk(clk), .rst(rst), .bus(if81));
    serial_adder #(.WIDTH(8),  .DIGIT(4)) u_add_8x4  (.clk(clk), .rst(rst), .bus(if84));
    serial_adder #(.WIDTH(16), .DIGIT(2)) u_add_16x2 (.clk(clk), .rst(rst), .bus(if162));

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        ovf;
    } res_t;

    res_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Independent reference: full-width integer sum, overflow from operand/result signs.
    function automatic res_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic ci, input logic sb);
        res_t        r;
        logic [15:0] mask;
        logic [15:0] aa;
        logic [15:0] bb;
        logic [16:0] full;
        logic        cc;
        mask  = (w == 16) ? 16'hFFFF : 16'h00FF;
        aa    = a & mask;
        bb    = (sb ? ~b : b) & mask;
        cc    = sb ? 1'b1 : ci;
        full  = {1'b0, aa} + {1'b0, bb} + {16'h0, cc};
        r.s   = full[15:0] & mask;
        r.c   = full[w];
        r.ovf = (aa[w-1] == bb[w-1]) && (r.s[w-1] != aa[w-1]);
        return r;
    endfunction

    task automatic drive(input int d, input logic st, input logic [15:0] a, input logic [15:0] b,
                         input logic ci);
        case (d)
            0: begin if81.start = st;  if81.a = a[7:0];  if81.b = b[7:0];  if81.cin = ci;  end
            1: begin if84.start = st;  if84.a = a[7:0];  if84.b = b[7:0];  if84.cin = ci;  end
            default: begin if162.start = st; if162.a = a; if162.b = b; if162.cin = ci; end
        endcase
    endtask

    task automatic sample(input int d, output logic bsy, output logic dn, output logic [15:0] s,
                          output logic c, output logic ovf);
        case (d)
            0: begin bsy = if81.busy; dn = if81.done; s = {8'h0, if81.s}; c = if81.c; ovf = if81.ovf; end
            1: begin bsy = if84.busy; dn = if84.done; s = {8'h0, if84.s}; c = if84.c; ovf = if84.ovf; end
            default: begin bsy = if162.busy; dn = if162.done; s = if162.s; c = if162.c; ovf = if162.ovf; end
        endcase
    endtask

    task automatic test_reset();
        logic bsy, dn, c, ovf;
        logic [15:0] s;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            sample(d, bsy, dn, s, c, ovf);
            n_cmp++;
            if ({bsy, dn, s, c, ovf} !== 20'h0) begin
                n_bad++;
                $display("FAIL reset[%0d]: got busy=%b done=%b s=%h c=%b ovf=%b, expected all zero",
                         d, bsy, dn, s, c, ovf);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_add_carry();
        logic bsy, dn, c, ovf;
        logic [15:0] s;
        res_t r;
        @(negedge clk);
        drive(0, 1'b1, 16'hFF, 16'h01, 1'b0);
        exp_q.push_back('{s: 16'h00, c: 1'b1, ovf: 1'b0});
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
            sample(0, bsy, dn, s, c, ovf);
            n_cmp++;
            if (bsy !== 1'b1 || dn !== 1'b0 || s !== 16'h0) begin
                n_bad++;
                $display("FAIL add_carry_run[%0d]: got busy=%b done=%b s=%h, expected 1 0 0000", i, bsy, dn, s);
            end
        end
        @(negedge clk);
        sample(0, bsy, dn, s, c, ovf);
        r = exp_q.pop_front();
        n_cmp++;
        if (bsy !== 1'b0 || dn !== 1'b1 || {s, c, ovf} !== {r.s, r.c, r.ovf}) begin
            n_bad++;
            $display("FAIL add_carry_done: got busy=%b done=%b s=%h c=%b ovf=%b, expected 0 1 %h %b %b",
                     bsy, dn, s, c, ovf, r.s, r.c, r.ovf);
        end
        @(negedge clk);
        sample(0, bsy, dn, s, c, ovf);
        n_cmp++;
        if (dn !== 1'b0) begin
            n_bad++;
            $display("FAIL add_carry_pulse: got done=%b, expected 0", dn);
        end
    endtask

    task automatic test_overflow_ignore();
        logic bsy, dn, c, ovf;
        logic [15:0] s;
        res_t r;
        int ndone = 0;
        drive(0, 1'b1, 16'h7F, 16'h01, 1'b0);
        exp_q.push_back('{s: 16'h80, c: 1'b0, ovf: 1'b1});
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
            if (i == 3) drive(0, 1'b1, 16'h11, 16'h22, 1'b1);
            if (i == 4) drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
            sample(0, bsy, dn, s, c, ovf);
            if (dn) ndone++;
            n_cmp++;
            if (bsy !== 1'b1 || s !== 16'h00) begin
                n_bad++;
                $display("FAIL ovf_run[%0d]: got busy=%b s=%h, expected 1 00", i, bsy, s);
            end
        end
        @(negedge clk);
        sample(0, bsy, dn, s, c, ovf);
        if (dn) ndone++;
        r = exp_q.pop_front();
        n_cmp++;
        if (dn !== 1'b1 || {s, c, ovf} !== {r.s, r.c, r.ovf}) begin
            n_bad++;
            $display("FAIL ovf_done: got done=%b s=%h c=%b ovf=%b, expected 1 %h %b %b", dn, s, c, ovf, r.s, r.c, r.ovf);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            sample(0, bsy, dn, s, c, ovf);
            if (dn) ndone++;
        end
        n_cmp++;
        if (ndone != 1 || s !== 16'h80 || bsy !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_ignore: got dones=%0d s=%h busy=%b, expected 1 80 0", ndone, s, bsy);
        end
    endtask

    task automatic test_digit4();
        logic bsy, dn, c, ovf;
        logic [15:0] s;
        logic [15:0] ra, rb;
        logic rc;
        logic prev_dn = 1'b0;
        res_t r;
        int pushed = 0;
        int got = 0;
        drive(1, 1'b1, 16'h3C, 16'h0F, 1'b1);
        exp_q.push_back('{s: 16'h4C, c: 1'b0, ovf: 1'b0});
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (i == 0) drive(1, 1'b0, 16'h0, 16'h0, 1'b0);
            sample(1, bsy, dn, s, c, ovf);
            n_cmp++;
            if (bsy !== 1'b1 || dn !== 1'b0) begin
                n_bad++;
                $display("FAIL d4_run[%0d]: got busy=%b done=%b, expected 1 0", i, bsy, dn);
            end
        end
        @(negedge clk);
        sample(1, bsy, dn, s, c, ovf);
        r = exp_q.pop_front();
        n_cmp++;
        if (dn !== 1'b1 || {s, c, ovf} !== {r.s, r.c, r.ovf}) begin
            n_bad++;
            $display("FAIL d4_done: got done=%b s=%h c=%b ovf=%b, expected 1 %h %b %b", dn, s, c, ovf, r.s, r.c, r.ovf);
        end
        // Back-to-back with start held high: operands refreshed whenever the block is idle.
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            @(negedge clk);
            sample(1, bsy, dn, s, c, ovf);
            if (prev_dn) begin
                n_cmp++;
                if (bsy !== 1'b1 || dn !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_gap: got busy=%b done=%b after done, expected 1 0", bsy, dn);
                end
            end
            if (dn) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL b2b_extra: got unexpected done s=%h, expected none", s);
                end else begin
                    r = exp_q.pop_front();
                    if ({s, c, ovf} !== {r.s, r.c, r.ovf}) begin
                        n_bad++;
                        $display("FAIL b2b_result: got s=%h c=%b ovf=%b, expected %h %b %b", s, c, ovf, r.s, r.c, r.ovf);
                    end
                end
                got++;
            end
            prev_dn = dn;
            if (!bsy) begin
                if (pushed < 4) begin
                    ra = 16'($urandom_range(0, 255));
                    rb = 16'($urandom_range(0, 255));
                    rc = 1'($urandom_range(0, 1));
                    drive(1, 1'b1, ra, rb, rc);
                    exp_q.push_back(model(8, ra, rb, rc, 1'b0));
                    pushed++;
                end else begin
                    drive(1, 1'b0, 16'h0, 16'h0, 1'b0);
                end
            end
        end
        drive(1, 1'b0, 16'h0, 16'h0, 1'b0);
        n_cmp++;
        if (got != 4 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d completions (%0d pending), expected 4 (0)", got, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_wide();
        logic bsy, dn, c, ovf;
        logic [15:0] s;
        res_t r;
        logic found = 1'b0;
        drive(2, 1'b1, 16'h1234, 16'h0101, 1'b0);
        exp_q.push_back('{s: 16'h1335, c: 1'b0, ovf: 1'b0});
        for (int t = 0; t < 20 && !found; t++) begin
            @(negedge clk);
            if (t == 0) drive(2, 1'b0, 16'h0, 16'h0, 1'b0);
            sample(2, bsy, dn, s, c, ovf);
            found = dn;
        end
        r = exp_q.pop_front();
        n_cmp++;
        if (!found || {s, c, ovf} !== {r.s, r.c, r.ovf}) begin
            n_bad++;
            $display("FAIL wide_first: got done=%b s=%h c=%b ovf=%b, expected 1 %h %b %b", found, s, c, ovf, r.s, r.c, r.ovf);
        end
        drive(2, 1'b1, 16'h8000, 16'h8000, 1'b0);
        exp_q.push_back('{s: 16'h0000, c: 1'b1, ovf: 1'b1});
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) drive(2, 1'b0, 16'h0, 16'h0, 1'b0);
            sample(2, bsy, dn, s, c, ovf);
            n_cmp++;
            if (bsy !== 1'b1 || dn !== 1'b0 || s !== 16'h1335) begin
                n_bad++;
                $display("FAIL wide_hold[%0d]: got busy=%b done=%b s=%h, expected 1 0 1335", i, bsy, dn, s);
            end
        end
        @(negedge clk);
        sample(2, bsy, dn, s, c, ovf);
        r = exp_q.pop_front();
        n_cmp++;
        if (dn !== 1'b1 || {s, c, ovf} !== {r.s, r.c, r.ovf}) begin
            n_bad++;
            $display("FAIL wide_done: got done=%b s=%h c=%b ovf=%b, expected 1 %h %b %b", dn, s, c, ovf, r.s, r.c, r.ovf);
        end
    endtask

    task automatic test_random();
        logic bsy, dn, c, ovf;
        logic [15:0] s;
        logic [15:0] ra, rb;
        logic rc;
        logic found;
        res_t r;
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 4; k++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                rc = 1'($urandom_range(0, 1));
                @(negedge clk);
                drive(d, 1'b1, ra, rb, rc);
                exp_q.push_back(model((d == 2) ? 16 : 8, ra, rb, rc, 1'b0));
                found = 1'b0;
                for (int t = 0; t < 20 && !found; t++) begin
                    @(negedge clk);
                    if (t == 0) drive(d, 1'b0, 16'h0, 16'h0, 1'b0);
                    sample(d, bsy, dn, s, c, ovf);
                    found = dn;
                end
                r = exp_q.pop_front();
                n_cmp++;
                if (!found || {s, c, ovf} !== {r.s, r.c, r.ovf}) begin
                    n_bad++;
                    $display("FAIL random[%0d.%0d]: got done=%b s=%h c=%b ovf=%b, expected 1 %h %b %b",
                             d, k, found, s, c, ovf, r.s, r.c, r.ovf);
                end
            end
        end
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        logic bsy, dn, c, ovf;
        logic [15:0] s;
        logic found;
        res_t r;
        logic [15:0] ta [2];
        logic [15:0] tb [2];
        ta[0] = 16'h05; tb[0] = 16'h07;
        ta[1] = 16'h80; tb[1] = 16'h01;
        exp_q.push_back('{s: 16'hFE, c: 1'b0, ovf: 1'b0});
        exp_q.push_back('{s: 16'h7F, c: 1'b1, ovf: 1'b1});
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(0, 1'b1, ta[k], tb[k], 1'b0);
            if81.sub = 1'b1;
            found = 1'b0;
            for (int t = 0; t < 20 && !found; t++) begin
                @(negedge clk);
                if (t == 0) begin
                    drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
                    if81.sub = 1'b0;
                end
                sample(0, bsy, dn, s, c, ovf);
                found = dn;
            end
            r = exp_q.pop_front();
            n_cmp++;
            if (!found || {s, c, ovf} !== {r.s, r.c, r.ovf}) begin
                n_bad++;
                $display("FAIL sub[%0d]: got done=%b s=%h c=%b ovf=%b, expected 1 %h %b %b",
                         k, found, s, c, ovf, r.s, r.c, r.ovf);
            end
        end
    endtask
`endif

    task automatic test_reset_mid();
        logic bsy, dn, c, ovf;
        logic [15:0] s;
        int ndone = 0;
        @(negedge clk);
        drive(0, 1'b1, 16'h55, 16'h0A, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sample(0, bsy, dn, s, c, ovf);
        n_cmp++;
        if ({bsy, dn, s, c, ovf} !== 20'h0) begin
            n_bad++;
            $display("FAIL reset_mid: got busy=%b done=%b s=%h c=%b ovf=%b, expected all zero", bsy, dn, s, c, ovf);
        end
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            sample(0, bsy, dn, s, c, ovf);
            if (dn || bsy) ndone++;
        end
        n_cmp++;
        if (ndone != 0) begin
            n_bad++;
            $display("FAIL reset_mid_quiet: got %0d busy/done cycles after reset, expected 0", ndone);
        end
    endtask

    initial begin
`ifdef SERIAL_ADDER_SUB_EN
        if81.sub = 1'b0;
`endif
        test_reset();
        test_add_carry();
        test_overflow_ignore();
        test_digit4();
        test_wide();
        test_random();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
